// File: rtl/time_entry_pkg.sv
// Shared definitions for the time/alarm keypad entry block: FSM states,
// digit range limits, target selectors and the per-position range check.
package time_entry_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_H1,
    ST_H0,
    ST_M1,
    ST_M0,
    ST_COMMIT
  } state_t;

  localparam logic [3:0] MAX_H1       = 4'd2;
  localparam logic [3:0] MAX_H0_AT_20 = 4'd3;
  localparam logic [3:0] MAX_M1       = 4'd5;
  localparam logic [3:0] MAX_DIGIT    = 4'd9;

  localparam logic TARGET_TIME  = 1'b0;
  localparam logic TARGET_ALARM = 1'b1;

  // The H0 limit depends on the already-accepted H1 digit (20..23 only).
  function automatic logic digit_ok(input state_t s, input logic [1:0] h1,
                                    input logic [3:0] d);
    logic ok;
    ok = 1'b0;
    case (s)
      ST_H1:   ok = (d <= MAX_H1);
      ST_H0:   ok = ({2'b00, h1} == MAX_H1) ? (d <= MAX_H0_AT_20) : (d <= MAX_DIGIT);
      ST_M1:   ok = (d <= MAX_M1);
      ST_M0:   ok = (d <= MAX_DIGIT);
      default: ok = 1'b0;
    endcase
    return ok;
  endfunction

endpackage

// File: rtl/time_entry_bcd2bin.sv
// Two-digit BCD (tens, units) to 6-bit binary, the inverse of the display split.
module bcd2bin (
  input  logic [3:0] i_tens,
  input  logic [3:0] i_units,
  output logic [5:0] o_bin
);

  logic [5:0] w_tens;
  logic [5:0] w_units;

  assign w_tens  = {2'b00, i_tens};
  assign w_units = {2'b00, i_units};
  // tens*10 as tens*8 + tens*2; inputs are range-checked so the sum fits 6 bits
  assign o_bin   = (w_tens << 3) + (w_tens << 1) + w_units;

endmodule

// File: rtl/time_entry.sv
// Keypad entry of an HH:MM value for either the clock or the alarm; digits are
// range-checked as they arrive and the result is published with a set_valid pulse.
module time_entry
  import time_entry_pkg::*;
(
  input  logic       clk,
  input  logic       rst_n,
  input  logic       start,
  input  logic       target_in,
  input  logic       digit_valid,
  input  logic [3:0] digit,
  input  logic       cancel,
  output logic       busy,
  output logic [1:0] e_hour1,
  output logic [3:0] e_hour0,
  output logic [3:0] e_min1,
  output logic [3:0] e_min0,
  output logic [5:0] set_hour,
  output logic [5:0] set_minute,
  output logic [5:0] set_second,
  output logic       set_target,
  output logic       set_valid,
  output logic       err
);

  state_t     r_state;
  state_t     w_next;
  logic       r_target;
  logic [1:0] r_h1;
  logic [3:0] r_h0;
  logic [3:0] r_m1;
  logic [3:0] r_m0;
  logic [5:0] r_set_hour;
  logic [5:0] r_set_minute;
  logic       r_set_target;
  logic       r_commit;
  logic       r_set_valid;
  logic       r_err;

  logic       w_entry;
  logic       w_ok;
  logic       w_accept;
  logic       w_reject;
  logic       w_commit;
  logic       w_begin;
  logic       w_abort;
  logic [5:0] w_hour;
  logic [5:0] w_minute;

  bcd2bin u_hour (
    .i_tens  ({2'b00, r_h1}),
    .i_units (r_h0),
    .o_bin   (w_hour)
  );

  bcd2bin u_minute (
    .i_tens  (r_m1),
    .i_units (r_m0),
    .o_bin   (w_minute)
  );

  always_comb begin
    w_entry  = (r_state == ST_H1) || (r_state == ST_H0) ||
               (r_state == ST_M1) || (r_state == ST_M0);
    w_ok     = digit_ok(r_state, r_h1, digit);
    w_accept = w_entry && digit_valid && !cancel && w_ok;
    w_reject = w_entry && digit_valid && !cancel && !w_ok;
    w_commit = (r_state == ST_COMMIT) && !cancel;
    w_begin  = (r_state == ST_IDLE) && start;
    w_abort  = (r_state != ST_IDLE) && cancel;
  end

  always_comb begin
    w_next = r_state;
    case (r_state)
      ST_IDLE:   if (start) w_next = ST_H1;
      ST_H1:     if (cancel) w_next = ST_IDLE; else if (w_accept) w_next = ST_H0;
      ST_H0:     if (cancel) w_next = ST_IDLE; else if (w_accept) w_next = ST_M1;
      ST_M1:     if (cancel) w_next = ST_IDLE; else if (w_accept) w_next = ST_M0;
      ST_M0:     if (cancel) w_next = ST_IDLE; else if (w_accept) w_next = ST_COMMIT;
      ST_COMMIT: w_next = ST_IDLE;
      default:   w_next = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_state <= ST_IDLE;
    else        r_state <= w_next;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_target <= TARGET_TIME;
      r_h1     <= '0;
      r_h0     <= '0;
      r_m1     <= '0;
      r_m0     <= '0;
    end else if (w_begin || w_abort) begin
      if (w_begin) r_target <= target_in;
      r_h1 <= '0;
      r_h0 <= '0;
      r_m1 <= '0;
      r_m0 <= '0;
    end else if (w_accept) begin
      case (r_state)
        ST_H1:   r_h1 <= digit[1:0];
        ST_H0:   r_h0 <= digit;
        ST_M1:   r_m1 <= digit;
        ST_M0:   r_m0 <= digit;
        default: ;
      endcase
    end
  end

  // Results are captured on the COMMIT edge; set_valid follows one edge later
  // so it lands on the second edge after the M0 digit is sampled.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_set_hour   <= '0;
      r_set_minute <= '0;
      r_set_target <= TARGET_TIME;
      r_commit     <= 1'b0;
      r_set_valid  <= 1'b0;
      r_err        <= 1'b0;
    end else begin
      if (w_commit) begin
        r_set_hour   <= w_hour;
        r_set_minute <= w_minute;
        r_set_target <= r_target;
      end
      r_commit    <= w_commit;
      r_set_valid <= r_commit;
      r_err       <= w_reject;
    end
  end

  assign busy       = (r_state != ST_IDLE);
  assign e_hour1    = r_h1;
  assign e_hour0    = r_h0;
  assign e_min1     = r_m1;
  assign e_min0     = r_m0;
  assign set_hour   = r_set_hour;
  assign set_minute = r_set_minute;
  assign set_second = '0;
  assign set_target = r_set_target;
  assign set_valid  = r_set_valid;
  assign err        = r_err;

endmodule

// File: tb/tb_time_entry.sv
// Self-checking bench for time_entry: directed scenarios plus a randomized run
// compared every cycle against a digit-position reference model.
module tb_time_entry;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       start;
  logic       target_in;
  logic       digit_valid;
  logic [3:0] digit;
  logic       cancel;
  logic       busy;
  logic [1:0] e_hour1;
  logic [3:0] e_hour0;
  logic [3:0] e_min1;
  logic [3:0] e_min0;
  logic [5:0] set_hour;
  logic [5:0] set_minute;
  logic [5:0] set_second;
  logic       set_target;
  logic       set_valid;
  logic       err;

  int n_cmp = 0;
  int n_err = 0;

  // Model: m_pos 0 = idle, 1..4 = waiting for digit n, 5 = commit cycle
  int m_pos;
  int m_dg[4];
  int m_tgt, m_sh, m_sm, m_st, m_pend, m_valid, m_err;

  time_entry dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .start       (start),
    .target_in   (target_in),
    .digit_valid (digit_valid),
    .digit       (digit),
    .cancel      (cancel),
    .busy        (busy),
    .e_hour1     (e_hour1),
    .e_hour0     (e_hour0),
    .e_min1      (e_min1),
    .e_min0      (e_min0),
    .set_hour    (set_hour),
    .set_minute  (set_minute),
    .set_second  (set_second),
    .set_target  (set_target),
    .set_valid   (set_valid),
    .err         (err)
  );

  always #5 clk = ~clk;

  task automatic model_reset();
    m_pos = 0; m_tgt = 0; m_sh = 0; m_sm = 0; m_st = 0;
    m_pend = 0; m_valid = 0; m_err = 0;
    for (int i = 0; i < 4; i++) m_dg[i] = 0;
  endtask

  function automatic int limit_for(input int pos);
    case (pos)
      1:       return 2;
      2:       return (m_dg[0] == 2) ? 3 : 9;
      3:       return 5;
      default: return 9;
    endcase
  endfunction

  // Apply one cycle of inputs, wait for the edge, then advance the model.
  task automatic step(input logic st, input logic tg, input logic dv,
                      input logic [3:0] d, input logic cn);
    start = st; target_in = tg; digit_valid = dv; digit = d; cancel = cn;
    @(posedge clk);
    #1;
    m_valid = m_pend;
    m_pend  = 0;
    m_err   = 0;
    if (m_pos == 0) begin
      if (st) begin
        m_pos = 1; m_tgt = int'(tg);
        for (int i = 0; i < 4; i++) m_dg[i] = 0;
      end
    end else if (cn) begin
      m_pos = 0;
      for (int i = 0; i < 4; i++) m_dg[i] = 0;
    end else if (m_pos == 5) begin
      m_sh = m_dg[0] * 10 + m_dg[1];
      m_sm = m_dg[2] * 10 + m_dg[3];
      m_st = m_tgt;
      m_pend = 1;
      m_pos = 0;
    end else if (dv) begin
      if (int'(d) <= limit_for(m_pos)) begin
        m_dg[m_pos-1] = int'(d);
        m_pos = m_pos + 1;
      end else begin
        m_err = 1;
      end
    end
  endtask

  task automatic idle();
    step(1'b0, 1'b0, 1'b0, 4'd0, 1'b0);
  endtask

  task automatic key(input logic [3:0] d);
    step(1'b0, 1'b0, 1'b1, d, 1'b0);
  endtask

  task automatic test_reset();
    rst_n = 1'b0; start = 0; target_in = 0; digit_valid = 0; digit = 0; cancel = 0;
    #3;
    model_reset();
    n_cmp++;
    if ({busy, set_valid, err, set_target} !== 4'b0000) begin
      n_err++; $display("FAIL reset_ctrl: got %b want 0000", {busy, set_valid, err, set_target});
    end
    n_cmp++;
    if ({set_hour, set_minute, set_second} !== 18'd0) begin
      n_err++; $display("FAIL reset_set: got %0d/%0d/%0d want 0/0/0", set_hour, set_minute, set_second);
    end
    n_cmp++;
    if ({e_hour1, e_hour0, e_min1, e_min0} !== 14'd0) begin
      n_err++; $display("FAIL reset_echo: got %h want 0", {e_hour1, e_hour0, e_min1, e_min0});
    end
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic test_normal();
    step(1'b1, 1'b0, 1'b0, 4'd0, 1'b0);
    key(4'd1); key(4'd0); key(4'd2); key(4'd0);
    n_cmp++;
    if (busy !== 1'b1 || set_valid !== 1'b0) begin
      n_err++; $display("FAIL normal_commit: busy=%b valid=%b want 1/0", busy, set_valid);
    end
    idle();
    n_cmp++;
    if (set_valid !== 1'b0 || busy !== 1'b0) begin
      n_err++; $display("FAIL normal_latency: valid=%b busy=%b want 0/0", set_valid, busy);
    end
    idle();
    n_cmp++;
    if (set_valid !== 1'b1 || set_hour !== 6'd10 || set_minute !== 6'd20 ||
        set_second !== 6'd0 || set_target !== 1'b0) begin
      n_err++; $display("FAIL normal_result: valid=%b %0d:%0d:%0d tgt=%b want 1 10:20:0 tgt=0",
                        set_valid, set_hour, set_minute, set_second, set_target);
    end
    idle();
    n_cmp++;
    if (set_valid !== 1'b0 || set_hour !== 6'd10 || set_minute !== 6'd20) begin
      n_err++; $display("FAIL normal_hold: valid=%b %0d:%0d want 0 10:20", set_valid, set_hour, set_minute);
    end
  endtask

  task automatic test_boundary();
    step(1'b1, 1'b1, 1'b0, 4'd0, 1'b0);
    key(4'd2); key(4'd3); key(4'd5); key(4'd9);
    n_cmp++;
    if ({e_hour1, e_hour0, e_min1, e_min0} !== {2'd2, 4'd3, 4'd5, 4'd9}) begin
      n_err++; $display("FAIL boundary_echo: got %0d/%0d/%0d/%0d want 2/3/5/9", e_hour1, e_hour0, e_min1, e_min0);
    end
    idle(); idle();
    n_cmp++;
    if (set_valid !== 1'b1 || set_hour !== 6'd23 || set_minute !== 6'd59 || set_target !== 1'b1) begin
      n_err++; $display("FAIL boundary_result: valid=%b %0d:%0d tgt=%b want 1 23:59 tgt=1",
                        set_valid, set_hour, set_minute, set_target);
    end
  endtask

  task automatic test_reject();
    step(1'b1, 1'b0, 1'b0, 4'd0, 1'b0);
    key(4'd2); key(4'd4);
    n_cmp++;
    if (err !== 1'b1 || e_hour0 !== 4'd0 || busy !== 1'b1) begin
      n_err++; $display("FAIL reject_h0: err=%b e_hour0=%0d busy=%b want 1/0/1", err, e_hour0, busy);
    end
    key(4'd3);
    n_cmp++;
    if (err !== 1'b0 || e_hour0 !== 4'd3) begin
      n_err++; $display("FAIL reject_recover: err=%b e_hour0=%0d want 0/3", err, e_hour0);
    end
    key(4'd0); key(4'd0); idle(); idle();
    n_cmp++;
    if (set_valid !== 1'b1 || set_hour !== 6'd23 || set_minute !== 6'd0) begin
      n_err++; $display("FAIL reject_result: valid=%b %0d:%0d want 1 23:0", set_valid, set_hour, set_minute);
    end
  endtask

  task automatic test_invalid_codes();
    step(1'b1, 1'b0, 1'b0, 4'd0, 1'b0);
    key(4'd1); key(4'd2); key(4'd6);
    n_cmp++;
    if (err !== 1'b1 || e_min1 !== 4'd0) begin
      n_err++; $display("FAIL invalid_m1: err=%b e_min1=%0d want 1/0", err, e_min1);
    end
    key(4'd3); key(4'd12);
    n_cmp++;
    if (err !== 1'b1 || e_min0 !== 4'd0 || e_min1 !== 4'd3 || busy !== 1'b1) begin
      n_err++; $display("FAIL invalid_m0: err=%b e_min0=%0d e_min1=%0d busy=%b want 1/0/3/1",
                        err, e_min0, e_min1, busy);
    end
    key(4'd4); idle(); idle();
    n_cmp++;
    if (set_valid !== 1'b1 || set_hour !== 6'd12 || set_minute !== 6'd34) begin
      n_err++; $display("FAIL invalid_result: valid=%b %0d:%0d want 1 12:34", set_valid, set_hour, set_minute);
    end
  endtask

  task automatic test_abort();
    step(1'b1, 1'b1, 1'b0, 4'd0, 1'b0);
    key(4'd1); key(4'd2);
    step(1'b0, 1'b0, 1'b0, 4'd0, 1'b1);
    n_cmp++;
    if (busy !== 1'b0 || {e_hour1, e_hour0, e_min1, e_min0} !== 14'd0) begin
      n_err++; $display("FAIL abort_clear: busy=%b echo=%h want 0/0", busy, {e_hour1, e_hour0, e_min1, e_min0});
    end
    idle(); idle();
    n_cmp++;
    if (set_valid !== 1'b0 || set_hour !== 6'd12 || set_minute !== 6'd34 || set_target !== 1'b0) begin
      n_err++; $display("FAIL abort_hold: valid=%b %0d:%0d tgt=%b want 0 12:34 tgt=0",
                        set_valid, set_hour, set_minute, set_target);
    end
    step(1'b1, 1'b0, 1'b0, 4'd0, 1'b0);
    step(1'b0, 1'b0, 1'b1, 4'd1, 1'b1);
    n_cmp++;
    if (busy !== 1'b0 || e_hour1 !== 2'd0 || err !== 1'b0) begin
      n_err++; $display("FAIL abort_priority: busy=%b e_hour1=%0d err=%b want 0/0/0", busy, e_hour1, err);
    end
    step(1'b1, 1'b0, 1'b0, 4'd0, 1'b0);
    key(4'd0); key(4'd1); key(4'd0); key(4'd0);
    step(1'b0, 1'b0, 1'b0, 4'd0, 1'b1);
    idle(); idle();
    n_cmp++;
    if (set_valid !== 1'b0 || set_hour !== 6'd12 || busy !== 1'b0) begin
      n_err++; $display("FAIL abort_commit: valid=%b hour=%0d busy=%b want 0/12/0", set_valid, set_hour, busy);
    end
  endtask

  task automatic test_reset_mid();
    step(1'b1, 1'b1, 1'b0, 4'd0, 1'b0);
    key(4'd1); key(4'd5); key(4'd3);
    rst_n = 1'b0;
    #1;
    model_reset();
    n_cmp++;
    if ({busy, set_valid, err, set_target, set_hour, set_minute, set_second,
         e_hour1, e_hour0, e_min1, e_min0} !== 36'd0) begin
      n_err++; $display("FAIL reset_mid: busy=%b valid=%b err=%b %0d:%0d echo=%h want all 0",
                        busy, set_valid, err, set_hour, set_minute, {e_hour1, e_hour0, e_min1, e_min0});
    end
    #2;
    rst_n = 1'b1;
    key(4'd5);
    n_cmp++;
    if (busy !== 1'b0 || err !== 1'b0 || {e_hour1, e_hour0, e_min1, e_min0} !== 14'd0) begin
      n_err++; $display("FAIL reset_idle_digit: busy=%b err=%b echo=%h want 0/0/0",
                        busy, err, {e_hour1, e_hour0, e_min1, e_min0});
    end
    idle(); idle();
    n_cmp++;
    if (set_valid !== 1'b0) begin
      n_err++; $display("FAIL reset_no_valid: valid=%b want 0", set_valid);
    end
  endtask

  task automatic test_random();
    logic [3:0] d;
    for (int n = 0; n < 600; n++) begin
      d = ($urandom_range(0, 5) == 0) ? 4'($urandom_range(10, 15)) : 4'($urandom_range(0, 9));
      step(($urandom_range(0, 7) == 0), 1'($urandom), ($urandom_range(0, 2) != 0), d,
           ($urandom_range(0, 24) == 0));
      n_cmp++;
      if (busy !== (m_pos != 0) || set_valid !== m_valid[0] || err !== m_err[0]) begin
        n_err++; $display("FAIL rand_ctrl@%0d: busy/valid/err=%b%b%b want %b%b%b", n,
                          busy, set_valid, err, (m_pos != 0), m_valid[0], m_err[0]);
      end
      n_cmp++;
      if ({e_hour1, e_hour0, e_min1, e_min0} !==
          {2'(m_dg[0]), 4'(m_dg[1]), 4'(m_dg[2]), 4'(m_dg[3])}) begin
        n_err++; $display("FAIL rand_echo@%0d: got %0d/%0d/%0d/%0d want %0d/%0d/%0d/%0d", n,
                          e_hour1, e_hour0, e_min1, e_min0, m_dg[0], m_dg[1], m_dg[2], m_dg[3]);
      end
      n_cmp++;
      if (set_hour !== 6'(m_sh) || set_minute !== 6'(m_sm) || set_second !== 6'd0 ||
          set_target !== m_st[0]) begin
        n_err++; $display("FAIL rand_set@%0d: got %0d:%0d:%0d tgt=%b want %0d:%0d:0 tgt=%0d", n,
                          set_hour, set_minute, set_second, set_target, m_sh, m_sm, m_st);
      end
    end
  endtask

  initial begin
    test_reset();
    test_normal();
    test_boundary();
    test_reject();
    test_invalid_codes();
    test_abort();
    test_reset_mid();
    test_random();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
